// File: rtl/fifo_write_skid_if.sv
// Handshake bundle between an upstream producer, the write skid buffer and a standard FIFO write port.
interface fifo_write_skid_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             fifo_wren;
    logic [WIDTH-1:0] fifo_din;
    logic             fifo_full;
    logic             fifo_almost_full;
    logic             idle;

    // Skid buffer side
    modport slave (
        input  in_valid, in_data, fifo_full, fifo_almost_full,
        output in_ready, fifo_wren, fifo_din, idle
    );

    // Producer/FIFO side
    modport master (
        output in_valid, in_data, fifo_full, fifo_almost_full,
        input  in_ready, fifo_wren, fifo_din, idle
    );
endinterface

// File: rtl/fifo_write_skid.sv
// Two-entry skid buffer feeding a standard FIFO write port; in_ready is registered and never sees fifo_full.
// Optional statistics (wr_count, stall_count, af_seen) are enabled by defining FIFO_WRITE_SKID_STATS_EN.
module fifo_write_skid #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DELAY = 1
) (
    input  logic        CLK,
    input  logic        RESET_N,
`ifdef FIFO_WRITE_SKID_STATS_EN
    output logic [31:0] wr_count,
    output logic [15:0] stall_count,
    output logic        af_seen,
`endif
    fifo_write_skid_if.slave bus
);
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_TWO   = 2'b11;

    logic             r_main_valid, r_skid_valid, r_in_ready;
    logic [WIDTH-1:0] r_main_data, r_skid_data;

    logic             w_main_valid_d, w_skid_valid_d, w_in_ready_d;
    logic [WIDTH-1:0] w_main_data_d, w_skid_data_d;
    logic             w_accept, w_write;
    logic [1:0]       w_state;

    assign w_accept = bus.in_valid && r_in_ready;
    assign w_write  = r_main_valid && !bus.fifo_full;
    assign w_state  = {r_skid_valid, r_main_valid};

    assign bus.fifo_wren = w_write;
    assign bus.fifo_din  = r_main_data;
    assign bus.in_ready  = r_in_ready;
    assign bus.idle      = !r_main_valid && !r_skid_valid;

    // Next-state: the valid bits themselves encode EMPTY/ONE/TWO
    always_comb begin
        w_main_valid_d = r_main_valid;
        w_skid_valid_d = r_skid_valid;
        w_main_data_d  = r_main_data;
        w_skid_data_d  = r_skid_data;
        case (w_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_main_data_d  = bus.in_data;
                    w_main_valid_d = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_write) begin
                    w_main_data_d = bus.in_data;
                end else if (w_accept) begin
                    w_skid_data_d  = bus.in_data;
                    w_skid_valid_d = 1'b1;
                end else if (w_write) begin
                    w_main_valid_d = 1'b0;
                end
            end
            ST_TWO: begin
                if (w_write) begin
                    w_main_data_d  = r_skid_data;
                    w_skid_valid_d = 1'b0;
                end
            end
            default: begin
                w_main_valid_d = 1'b0;
                w_skid_valid_d = 1'b0;
            end
        endcase
        w_in_ready_d = !w_skid_valid_d;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
            r_main_data  <= '0;
            r_skid_data  <= '0;
        end else begin
            r_main_valid <= w_main_valid_d;
            r_skid_valid <= w_skid_valid_d;
            r_in_ready   <= w_in_ready_d;
            r_main_data  <= w_main_data_d;
            r_skid_data  <= w_skid_data_d;
        end
    end

`ifdef FIFO_WRITE_SKID_STATS_EN
    logic [31:0] r_wr_count;
    logic [15:0] r_stall_count;
    logic        r_af_seen;

    // Write count wraps; stall count saturates; almost-full flag is sticky until reset
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_wr_count    <= 32'd0;
            r_stall_count <= 16'd0;
            r_af_seen     <= 1'b0;
        end else begin
            if (w_write)
                r_wr_count <= r_wr_count + 32'd1;
            if (r_main_valid && bus.fifo_full && (r_stall_count != 16'hFFFF))
                r_stall_count <= r_stall_count + 16'd1;
            if (bus.fifo_almost_full)
                r_af_seen <= 1'b1;
        end
    end

    assign wr_count    = r_wr_count;
    assign stall_count = r_stall_count;
    assign af_seen     = r_af_seen;

    // DELAY only shapes behavioural models; this logic is zero-delay
    logic w_unused;
    assign w_unused = ^{1'b0, 32'(DELAY)};
`else
    // DELAY only shapes behavioural models; almost-full matters only with statistics
    logic w_unused;
    assign w_unused = ^{1'b0, 32'(DELAY), bus.fifo_almost_full};
`endif
endmodule

// File: tb/tb_fifo_write_skid.sv
// Directed-vector and scoreboard bench for fifo_write_skid (statistics checks when FIFO_WRITE_SKID_STATS_EN is defined).
module tb_fifo_write_skid;
    localparam int unsigned WIDTH = 32;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    fifo_write_skid_if #(.WIDTH(WIDTH)) bus();

`ifdef FIFO_WRITE_SKID_STATS_EN
    logic [31:0] wr_count;
    logic [15:0] stall_count;
    logic        af_seen;
`endif

    fifo_write_skid #(.WIDTH(WIDTH), .DELAY(1)) dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
`ifdef FIFO_WRITE_SKID_STATS_EN
        .wr_count   (wr_count),
        .stall_count(stall_count),
        .af_seen    (af_seen),
`endif
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        in_valid;
        logic [31:0] in_data;
        logic        fifo_full;
        logic        exp_ready;
        logic        exp_wren;
        logic [31:0] exp_din;
        logic        exp_idle;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [31:0] d,
                         input logic ff, input logic af);
        rst_n                = r;
        bus.in_valid         = iv;
        bus.in_data          = d;
        bus.fifo_full        = ff;
        bus.fifo_almost_full = af;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] word;
        logic        iv;
        int          sent, recv, ovf;

        n_checks = 0;
        n_fail   = 0;

        //            rst iv data          ff  rdy wren din           idle
        vecs[0]  = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 32'h1,    1'b0, 1'b0, 1'b0, 32'h0, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 32'h1,    1'b0, 1'b1, 1'b0, 32'h0, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 32'h2,    1'b0, 1'b1, 1'b1, 32'h1, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 32'h3,    1'b0, 1'b1, 1'b1, 32'h2, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 32'h4,    1'b1, 1'b1, 1'b0, 32'h3, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 32'h5,    1'b1, 1'b0, 1'b0, 32'h3, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 32'h5,    1'b1, 1'b0, 1'b0, 32'h3, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 32'h5,    1'b0, 1'b0, 1'b1, 32'h3, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'hDEAD, 1'b0, 1'b1, 1'b1, 32'h4, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'hBEEF, 1'b0, 1'b1, 1'b0, 32'h4, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 32'hA,    1'b1, 1'b1, 1'b0, 32'h4, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 32'hB,    1'b1, 1'b1, 1'b0, 32'hA, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 32'hC,    1'b1, 1'b0, 1'b0, 32'hA, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 32'h0, 1'b1};

        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) tick();

        // Reset, throughput, skid fill, drain, and reset while holding two words
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst_n, vecs[i].in_valid, vecs[i].in_data, vecs[i].fifo_full, 1'b0);
            chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_ready));
            chk($sformatf("vec%0d_fifo_wren", i), 32'(bus.fifo_wren), 32'(vecs[i].exp_wren));
            chk($sformatf("vec%0d_fifo_din", i), bus.fifo_din, vecs[i].exp_din);
            chk($sformatf("vec%0d_idle", i), 32'(bus.idle), 32'(vecs[i].exp_idle));
            tick();
        end

        // Five full cycles from ONE: one word goes to skid, then both drain in order
        drive(1'b1, 1'b1, 32'h100, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 32'h101 + 32'(k), 1'b1, 1'b0);
            chk($sformatf("full%0d_wren", k), 32'(bus.fifo_wren), 32'd0);
            chk($sformatf("full%0d_ready", k), 32'(bus.in_ready), (k == 0) ? 32'd1 : 32'd0);
            tick();
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("drain0_wren", 32'(bus.fifo_wren), 32'd1);
        chk("drain0_din", bus.fifo_din, 32'h100);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("drain1_wren", 32'(bus.fifo_wren), 32'd1);
        chk("drain1_din", bus.fifo_din, 32'h101);
        chk("drain1_ready", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("drain_idle", 32'(bus.idle), 32'd1);
        chk("drain_wren", 32'(bus.fifo_wren), 32'd0);

        // Random valid/full traffic against an in-order scoreboard
        sent = 0;
        recv = 0;
        ovf  = 0;
        word = $urandom;
        for (int cyc = 0; cyc < 20000 && recv < 1000; cyc++) begin
            iv = (sent < 1000) && ($urandom_range(0, 1) == 1);
            drive(1'b1, iv, iv ? word : $urandom, 1'($urandom_range(0, 1)), 1'b0);
            if (bus.fifo_wren && bus.fifo_full) ovf++;
            if (bus.fifo_wren) begin
                if (q.size() == 0) begin
                    chk("rand_spurious_write", bus.fifo_din, 32'hFFFF_FFFF ^ bus.fifo_din);
                end else begin
                    chk("rand_order", bus.fifo_din, q.pop_front());
                end
                recv++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(word);
                sent++;
                word = $urandom;
            end
            tick();
        end
        chk("rand_received", 32'(recv), 32'd1000);
        chk("rand_overflow", 32'(ovf), 32'd0);

`ifdef FIFO_WRITE_SKID_STATS_EN
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        chk("stats_reset_wr", wr_count, 32'd0);
        chk("stats_reset_stall", 32'(stall_count), 32'd0);
        chk("stats_reset_af", 32'(af_seen), 32'd0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 32'(i), 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        chk("stats_wr_count", wr_count, 32'd10);
        chk("stats_stall_count", 32'(stall_count), 32'd3);
        chk("stats_af_clear", 32'(af_seen), 32'd0);

        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
            chk($sformatf("stats_af_sticky%0d", i), 32'(af_seen), 32'd1);
            tick();
        end

        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        chk("stats_af_reset", 32'(af_seen), 32'd0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'h55, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 70000; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
            tick();
        end
        chk("stats_stall_saturate", 32'(stall_count), 32'h0000_FFFF);
        chk("stats_sat_wr", wr_count, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
